// File: rtl/simplex_lane_init_fsm.sv
// simplex_lane_init_fsm: rx lane bring-up sequencer (RST>ALIGN>BOND>VERIFY>READY) with watchdog and windowed error monitor; in: clk, rst (async high), lane_aligned/lane_bond_ok (levels), lane_verify/lane_err (strobes); out: aligned/bonded/verified/reset flags, state code, err_cnt
module simplex_lane_init_fsm #(
  parameter int LANES           = 4,
  parameter int RESET_CYCLES    = 16,
  parameter int VERIFY_COUNT    = 4,
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int ERR_WINDOW      = 256,
  parameter int ERR_LIMIT       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LANES-1:0]                 lane_aligned,
  input  logic [LANES-1:0]                 lane_bond_ok,
  input  logic [LANES-1:0]                 lane_verify,
  input  logic [LANES-1:0]                 lane_err,
  output logic                             aligned,
  output logic                             bonded,
  output logic                             verified,
  output logic                             reset,
  output logic [2:0]                       state,
  output logic [$clog2(ERR_LIMIT+1)-1:0]   err_cnt
);
  localparam int RW = $clog2(RESET_CYCLES+1);
  localparam int VW = $clog2(VERIFY_COUNT+1);
  localparam int WW = $clog2(WATCHDOG_CYCLES+1);
  localparam int NW = $clog2(ERR_WINDOW+1);
  localparam int EW = $clog2(ERR_LIMIT+1);
  localparam logic [RW-1:0] R_END  = RW'(RESET_CYCLES-1);
  localparam logic [VW-1:0] V_END  = VW'(VERIFY_COUNT);
  localparam logic [WW-1:0] WD_END = WW'(WATCHDOG_CYCLES-1);
  localparam logic [NW-1:0] N_END  = NW'(ERR_WINDOW-1);
  localparam logic [EW-1:0] E_END  = EW'(ERR_LIMIT);
  typedef enum logic [2:0] {RST = 3'd0, ALIGN = 3'd1, BOND = 3'd2, VERIFY = 3'd3, READY = 3'd4} state_t;
  state_t cur, nxt;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic [WW-1:0] wd, wd_n;
  logic [NW-1:0] win, win_n;
  logic [EW-1:0] err_n;
  logic al, bo, fv, pv, er, lost, wd_hit, wrap;
  assign state = cur;
  always_comb begin
    al     = &lane_aligned;
    bo     = &lane_bond_ok;
    fv     = &lane_verify;
    pv     = |lane_verify;
    er     = |lane_err;
    lost   = (cur == BOND && !al) || ((cur == VERIFY || cur == READY) && !(al && bo));
    wd_hit = wd == WD_END;
    wrap   = win == N_END;
    rcnt_n = cur == RST ? rcnt + 1'b1 : '0;
    vcnt_n = cur != VERIFY ? '0 : fv ? vcnt + 1'b1 : pv ? '0 : vcnt;
    wd_n   = (cur == ALIGN || cur == BOND || cur == VERIFY) ? wd + 1'b1 : '0;
    win_n  = (cur != READY || wrap) ? '0 : win + 1'b1;
    err_n  = cur != READY ? '0 : wrap ? EW'(er) : err_cnt + EW'(er);
    nxt    = cur;
    case (cur)
      RST:     nxt = rcnt == R_END ? ALIGN : RST;
      ALIGN:   nxt = wd_hit ? RST : al ? BOND : ALIGN;
      BOND:    nxt = (lost || wd_hit) ? RST : bo ? VERIFY : BOND;
      VERIFY:  nxt = (lost || wd_hit) ? RST : vcnt_n == V_END ? READY : VERIFY;
      READY:   nxt = (lost || err_n == E_END) ? RST : READY;
      default: nxt = RST;
    endcase
    if (nxt != cur) begin
      rcnt_n = '0;
      vcnt_n = '0;
      wd_n   = '0;
      win_n  = '0;
      err_n  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur      <= RST;
      rcnt     <= '0;
      vcnt     <= '0;
      wd       <= '0;
      win      <= '0;
      err_cnt  <= '0;
      aligned  <= 1'b0;
      bonded   <= 1'b0;
      verified <= 1'b0;
      reset    <= 1'b1;
    end else begin
      cur      <= nxt;
      rcnt     <= rcnt_n;
      vcnt     <= vcnt_n;
      wd       <= wd_n;
      win      <= win_n;
      err_cnt  <= err_n;
      aligned  <= nxt == BOND || nxt == VERIFY || nxt == READY;
      bonded   <= nxt == VERIFY || nxt == READY;
      verified <= nxt == READY;
      reset    <= nxt == RST;
    end
endmodule

// File: tb/tb_simplex_lane_init_fsm.sv
// tb_simplex_lane_init_fsm: randomized and directed checks of simplex_lane_init_fsm against a cycle model
module tb_simplex_lane_init_fsm;
  localparam int L = 4, RC = 16, VC = 4, WD = 1024, EWIN = 256, EL = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [L-1:0] la = '0, lb = '0, lv = '0, le = '0;
  logic aligned, bonded, verified, reset;
  logic [2:0] state;
  logic [3:0] err_cnt;
  int total = 0, passed = 0;
  int m_st = 0, m_rc = 0, m_dw = 0, m_vc = 0, m_pos = 0, m_err = 0, m_ns = 0;
  bit m_al, m_bo;
  always #5 clk = ~clk;
  simplex_lane_init_fsm #(
    .LANES(L), .RESET_CYCLES(RC), .VERIFY_COUNT(VC),
    .WATCHDOG_CYCLES(WD), .ERR_WINDOW(EWIN), .ERR_LIMIT(EL)
  ) dut (
    .clk(clk), .rst(rst),
    .lane_aligned(la), .lane_bond_ok(lb), .lane_verify(lv), .lane_err(le),
    .aligned(aligned), .bonded(bonded), .verified(verified), .reset(reset),
    .state(state), .err_cnt(err_cnt)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask
  // Reference: state as 0..4, elapsed-cycle counts per phase, priority list applied in order.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_st = 0; m_rc = 0; m_dw = 0; m_vc = 0; m_pos = 0; m_err = 0;
    end else begin
      m_al = &la;
      m_bo = &lb;
      m_ns = m_st;
      m_dw++;
      if (m_st == 0) begin
        m_rc++;
        if (m_rc == RC) m_ns = 1;
      end else if ((m_st >= 2 && !m_al) || (m_st >= 3 && !m_bo)) m_ns = 0;
      else if (m_st <= 3 && m_dw == WD) m_ns = 0;
      else if (m_st == 1) m_ns = m_al ? 2 : 1;
      else if (m_st == 2) m_ns = m_bo ? 3 : 2;
      else if (m_st == 3) begin
        if (&lv) m_vc++;
        else if (|lv) m_vc = 0;
        if (m_vc == VC) m_ns = 4;
      end else begin
        if (m_pos == EWIN - 1) m_err = 0;
        m_err += int'(|le);
        m_pos = (m_pos + 1) % EWIN;
        if (m_err == EL) m_ns = 0;
      end
      if (m_ns != m_st) begin
        m_rc = 0; m_dw = 0; m_vc = 0; m_pos = 0; m_err = 0;
      end
      m_st = m_ns;
    end
  always @(negedge clk) begin
    total++;
    if (int'(state) == m_st && aligned == (m_st >= 2) && bonded == (m_st >= 3) &&
        verified == (m_st == 4) && reset == (m_st == 0) && int'(err_cnt) == m_err)
      passed++;
    else
      $display("FAIL cycle t=%0t got st=%0d a=%0b b=%0b v=%0b r=%0b err=%0d expected st=%0d err=%0d",
               $time, state, aligned, bonded, verified, reset, err_cnt, m_st, m_err);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_st(input int s, input int budget);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_state", int'(state), s);
  endtask
  task automatic async_rst();
    la = '0; lb = '0; lv = '0; le = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_flags", int'({aligned, bonded, verified, reset}), 1);
    chk("rst_err", int'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic goto_bond();
    async_rst();
    wait_st(1, RC + 4);
    la = '1;
    cyc(1);
  endtask
  task automatic goto_verify();
    goto_bond();
    lb = '1;
    cyc(1);
  endtask
  task automatic goto_ready();
    goto_verify();
    lv = '1;
    cyc(VC);
    lv = '0;
  endtask
  initial begin
    #20_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin : main
    int n, off, r;
    #1 rst = 1'b1;
    cyc(2);
    chk("reset_state", int'(state), 0);
    rst = 1'b0;
    n = 0;
    while (reset && n < 100) begin
      n++;
      cyc(1);
    end
    chk("reset_len", n, RC);
    chk("align_entry", int'(state), 1);
    repeat ($urandom_range(0, 20)) begin
      la = 4'($urandom_range(0, 14));
      cyc(1);
    end
    la = '1;
    cyc(1);
    chk("aligned_up", int'(aligned), 1);
    repeat ($urandom_range(0, 20)) begin
      lb = 4'($urandom_range(0, 14));
      cyc(1);
    end
    lb = '1;
    cyc(1);
    chk("bonded_up", int'(bonded), 1);
    for (int k = 0; k < VC; k++) begin
      lv = '0;
      cyc($urandom_range(0, 3));
      lv = '1;
      cyc(1);
    end
    lv = '0;
    chk("bringup_state", int'(state), 4);
    chk("bringup_verified", int'(verified), 1);
    goto_verify();
    lv = '1;
    cyc(3);
    lv = '0;
    cyc(2);
    chk("three_full_not_ready", int'(state), 3);
    lv = 4'h7;
    cyc(1);
    lv = '1;
    cyc(3);
    lv = '0;
    cyc(2);
    chk("partial_not_ready", int'(state), 3);
    lv = '1;
    cyc(1);
    lv = '0;
    chk("partial_ready", int'(state), 4);
    goto_bond();
    n = 0;
    while (state == 3'd2 && n < 2000) begin
      lb = 4'($urandom_range(0, 14));
      cyc(1);
      n++;
    end
    chk("wd_dwell", n, WD);
    chk("wd_aligned_drop", int'(aligned), 0);
    chk("wd_state", int'(state), 0);
    goto_ready();
    off = $urandom_range(0, 29);
    for (int i = 0; i < EWIN; i++) begin
      le = (i % 30 == off && i < 210) ? 4'($urandom_range(1, 15)) : '0;
      cyc(1);
    end
    le = '1;
    cyc(7);
    le = '0;
    cyc(1);
    chk("err_two_windows", int'(err_cnt), 7);
    chk("err_stay_ready", int'(state), 4);
    le = 4'h2;
    cyc(1);
    le = '0;
    chk("err_limit_rst", int'(state), 0);
    goto_ready();
    cyc(EWIN - 1);
    le = 4'h8;
    cyc(1);
    le = '0;
    chk("err_wrap_load1", int'(err_cnt), 1);
    goto_bond();
    la = 4'hB;
    lb = '1;
    cyc(1);
    chk("align_loss_beats_bond", int'(state), 0);
    goto_ready();
    repeat (5) begin
      le = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : '0;
      cyc(1);
    end
    async_rst();
    wait_st(1, RC + 4);
    la = '1;
    cyc(1);
    lb = '1;
    cyc(1);
    lv = '1;
    cyc(VC);
    lv = '0;
    chk("rebringup_state", int'(state), 4);
    for (int i = 0; i < 4000; i++) begin
      la = ($urandom_range(0, 40) == 0) ? 4'($urandom) : '1;
      lb = ($urandom_range(0, 40) == 0) ? 4'($urandom) : '1;
      r  = $urandom_range(0, 5);
      lv = r < 2 ? '1 : r == 2 ? 4'($urandom_range(1, 14)) : '0;
      le = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : '0;
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
